// File: rtl/aes_selftest_ctrl.sv
// AES self-test sequencer: steps through the encrypt/decrypt chains selected
// by mod, lets each chain settle, compares its decryption output against the
// reference plaintext and records sticky pass/fail flags.
module aes_selftest_ctrl #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   mod,
  input  logic [127:0] pt_ref,
  input  logic [127:0] dec128,
  input  logic [127:0] dec192,
  input  logic [127:0] dec256,
  output logic [1:0]   sel,
  output logic         busy,
  output logic         done,
  output logic         led128,
  output logic         led192,
  output logic         led256,
  output logic         fail
);

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, CHECK, NEXT, DONE} state_t;

  state_t       state;
  logic [1:0]   mode;
  logic [3:0]   cnt;
  logic [127:0] dec_cur;
  logic         match;

  // Route the chain under test to the comparator; sel never reaches 11.
  always_comb begin
    dec_cur = dec128;
    case (sel)
      2'b01:   dec_cur = dec192;
      2'b10:   dec_cur = dec256;
      default: dec_cur = dec128;
    endcase
    match = (dec_cur == pt_ref);
  end

  // Sequencer with registered outputs; done is a default-low strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mode   <= 2'b00;
      cnt    <= 4'd0;
      sel    <= 2'b00;
      busy   <= 1'b0;
      done   <= 1'b0;
      led128 <= 1'b0;
      led192 <= 1'b0;
      led256 <= 1'b0;
      fail   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode   <= mod;
            led128 <= 1'b0;
            led192 <= 1'b0;
            led256 <= 1'b0;
            fail   <= 1'b0;
            sel    <= (mod == 2'b11) ? 2'b00 : mod;
            cnt    <= RELOAD;
            busy   <= 1'b1;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == 4'd0) state <= CHECK;
          else             cnt   <= cnt - 4'd1;
        end
        CHECK: begin
          if (match) begin
            case (sel)
              2'b00:   led128 <= 1'b1;
              2'b01:   led192 <= 1'b1;
              default: led256 <= 1'b1;
            endcase
          end else begin
            fail <= 1'b1;
          end
          if (mode == 2'b11 && sel != 2'b10) begin
            state <= NEXT;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        NEXT: begin
          sel   <= sel + 2'd1;
          cnt   <= RELOAD;
          state <= SETTLE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_selftest_ctrl.sv
// Self-checking bench for aes_selftest_ctrl: randomized vectors checked
// against a cycle-count / pass-set model derived from the test rules.
module tb_aes_selftest_ctrl;

  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   mod;
  logic [127:0] pt_ref, dec128, dec192, dec256;
  logic [1:0]   sel;
  logic         busy, done, led128, led192, led256, fail;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-cycle capture; index c = cycle c after the launching edge.
  logic       o_busy [0:63];
  logic       o_done [0:63];
  logic [1:0] o_sel  [0:63];
  logic [3:0] o_res  [0:63];

  aes_selftest_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .start(start), .mod(mod), .pt_ref(pt_ref),
    .dec128(dec128), .dec192(dec192), .dec256(dec256), .sel(sel),
    .busy(busy), .done(done), .led128(led128), .led192(led192),
    .led256(led256), .fail(fail)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int lat(input logic [1:0] m);
    return (m == 2'b11) ? 3 * S + 6 : S + 2;
  endfunction

  // Chain under test in cycle c: each chain occupies S settle + check + next.
  function automatic logic [1:0] exp_sel(input logic [1:0] m, input int c);
    int k;
    if (m != 2'b11) return m;
    k = (c - 1) / (S + 2);
    if (k > 2) k = 2;
    return 2'(k);
  endfunction

  // {fail, led256, led192, led128} after a run of mode m on current vectors.
  function automatic logic [3:0] exp_res(input logic [1:0] m);
    logic [2:0] tested, pass;
    tested = (m == 2'b11) ? 3'b111 : 3'(1 << m);
    pass   = {dec256 == pt_ref, dec192 == pt_ref, dec128 == pt_ref};
    return {|(tested & ~pass), tested & pass};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic set_vec(input logic [2:0] pass_mask);
    pt_ref = {$urandom, $urandom, $urandom, $urandom};
    dec128 = pass_mask[0] ? pt_ref : pt_ref ^ (128'd1 << $urandom_range(127, 0));
    dec192 = pass_mask[1] ? pt_ref : pt_ref ^ (128'd1 << $urandom_range(127, 0));
    dec256 = pass_mask[2] ? pt_ref : pt_ref ^ (128'd1 << $urandom_range(127, 0));
  endtask

  // Called at a negedge: arm start so it is sampled on the next rising edge.
  task automatic launch(input logic [1:0] m);
    mod   = m;
    start = 1'b1;
  endtask

  task automatic observe(input int n, input bit hold, input int inj_c,
                         input logic [1:0] inj_m, input int rst_c);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      o_busy[c] = busy;
      o_done[c] = done;
      o_sel[c]  = sel;
      o_res[c]  = {fail, led256, led192, led128};
      if (!hold) start = 1'b0;
      reset = 1'b0;
      if (c == inj_c) begin start = 1'b1; mod = inj_m; end
      if (c == rst_c) reset = 1'b1;
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b1; mod = 2'b11;
    set_vec(3'b111);
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({busy, done, sel, fail, led256, led192, led128} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_state: got %b expected 00000000",
               {busy, done, sel, fail, led256, led192, led128});
    end
    reset = 1'b0; start = 1'b0;
    observe(3, 0, 0, 2'b00, 0);
    for (int c = 1; c <= 3; c++) begin
      n_cmp++;
      if (o_busy[c] !== 1'b0) begin
        n_bad++; $display("FAIL reset_idle_busy c%0d: got %b expected 0", c, o_busy[c]);
      end
    end
  endtask

  task automatic test_vector_128();
    pt_ref = 128'h00112233445566778899aabbccffeeff;
    dec128 = pt_ref; dec192 = ~pt_ref; dec256 = ~pt_ref;
    launch(2'b00);
    observe(9, 0, 0, 2'b00, 0);
    for (int c = 1; c <= 9; c++) begin
      n_cmp++;
      if (o_busy[c] !== (c <= 6) || o_done[c] !== (c == 6)) begin
        n_bad++;
        $display("FAIL vec128_timing c%0d: got busy=%b done=%b expected busy=%b done=%b",
                 c, o_busy[c], o_done[c], c <= 6, c == 6);
      end
    end
    n_cmp++;
    if (o_res[7] !== 4'b0001) begin
      n_bad++; $display("FAIL vec128_result: got %b expected 0001", o_res[7]);
    end
  endtask

  task automatic test_random_runs();
    for (int it = 0; it < 10; it++) begin
      logic [1:0] m;
      int         l;
      logic [3:0] er;
      m = 2'($urandom_range(3, 0));
      if (it == 0) m = 2'b11;
      set_vec(it == 0 ? 3'b111 : (it == 1 ? 3'b101 : 3'($urandom)));
      if (it == 1) m = 2'b11;
      l  = lat(m);
      er = exp_res(m);
      launch(m);
      observe(l + 3, 0, 0, 2'b00, 0);
      for (int c = 1; c <= l + 3; c++) begin
        n_cmp++;
        if (o_busy[c] !== (c <= l) || o_done[c] !== (c == l) || o_sel[c] !== exp_sel(m, c)) begin
          n_bad++;
          $display("FAIL rand%0d_cycle c%0d m%0d: got busy=%b done=%b sel=%0d expected busy=%b done=%b sel=%0d",
                   it, c, m, o_busy[c], o_done[c], o_sel[c], c <= l, c == l, exp_sel(m, c));
        end
      end
      n_cmp++;
      if (o_res[1] !== 4'b0000) begin
        n_bad++; $display("FAIL rand%0d_clear: got %b expected 0000", it, o_res[1]);
      end
      n_cmp++;
      if (o_res[l] !== er || o_res[l + 3] !== er) begin
        n_bad++;
        $display("FAIL rand%0d_result m%0d: got %b/%b expected %b", it, m, o_res[l], o_res[l + 3], er);
      end
    end
  endtask

  task automatic test_ignore_start();
    int ndone;
    set_vec(3'b111);
    launch(2'b00);
    observe(S + 6, 0, 2, 2'b10, 0);
    ndone = 0;
    for (int c = 1; c <= S + 6; c++) begin
      if (o_done[c] === 1'b1) ndone++;
      n_cmp++;
      if (o_sel[c] !== 2'b00 || o_busy[c] !== (c <= S + 2)) begin
        n_bad++;
        $display("FAIL ignore_start c%0d: got sel=%0d busy=%b expected sel=0 busy=%b",
                 c, o_sel[c], o_busy[c], c <= S + 2);
      end
    end
    n_cmp++;
    if (ndone !== 1 || o_done[S + 2] !== 1'b1 || o_res[S + 6] !== 4'b0001) begin
      n_bad++;
      $display("FAIL ignore_result: got done_count=%0d res=%b expected 1 / 0001", ndone, o_res[S + 6]);
    end
  endtask

  task automatic test_reset_midrun();
    int rc [2];
    rc[0] = 2;
    rc[1] = 2 * S + 6;
    foreach (rc[i]) begin
      set_vec(3'b111);
      launch(2'b11);
      observe(3 * S + 10, 0, 0, 2'b00, rc[i]);
      n_cmp++;
      if ({o_busy[rc[i] + 1], o_sel[rc[i] + 1], o_res[rc[i] + 1]} !== 7'b0) begin
        n_bad++;
        $display("FAIL midrun_reset@%0d: got busy=%b sel=%0d res=%b expected all 0",
                 rc[i], o_busy[rc[i] + 1], o_sel[rc[i] + 1], o_res[rc[i] + 1]);
      end
      for (int c = 1; c <= 3 * S + 10; c++) begin
        n_cmp++;
        if (o_done[c] !== 1'b0) begin
          n_bad++; $display("FAIL midrun_no_done@%0d c%0d: got 1 expected 0", rc[i], c);
        end
      end
    end
  endtask

  task automatic test_led_clear();
    set_vec(3'b110);
    launch(2'b10);
    observe(S + 3, 0, 0, 2'b00, 0);
    n_cmp++;
    if (o_res[S + 3] !== 4'b0100) begin
      n_bad++; $display("FAIL ledclr_prev: got %b expected 0100", o_res[S + 3]);
    end
    launch(2'b00);
    observe(S + 3, 0, 0, 2'b00, 0);
    n_cmp++;
    if (o_res[1] !== 4'b0000) begin
      n_bad++; $display("FAIL ledclr_at_launch: got %b expected 0000", o_res[1]);
    end
    n_cmp++;
    if (o_res[S + 3] !== 4'b1000) begin
      n_bad++; $display("FAIL ledclr_result: got %b expected 1000", o_res[S + 3]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] m;
    int         d2;
    m  = 2'($urandom_range(2, 0));
    d2 = 2 * S + 5;
    set_vec(3'b111);
    launch(m);
    observe(d2 + 1, 1, 0, 2'b00, 0);
    for (int c = 1; c <= d2 + 1; c++) begin
      n_cmp++;
      if (o_done[c] !== (c == S + 2 || c == d2) ||
          o_busy[c] !== (c != S + 3 && c <= d2)) begin
        n_bad++;
        $display("FAIL b2b c%0d: got busy=%b done=%b expected busy=%b done=%b", c, o_busy[c],
                 o_done[c], c != S + 3 && c <= d2, c == S + 2 || c == d2);
      end
    end
    n_cmp++;
    if (o_res[S + 3] !== exp_res(m) || o_res[S + 4] !== 4'b0000 || o_res[d2 + 1] !== exp_res(m)) begin
      n_bad++;
      $display("FAIL b2b_leds: got %b/%b/%b expected %b/0000/%b", o_res[S + 3], o_res[S + 4],
               o_res[d2 + 1], exp_res(m), exp_res(m));
    end
    observe(3, 0, 0, 2'b00, 0);
  endtask

  initial begin
    test_reset();
    test_vector_128();
    test_random_runs();
    test_ignore_start();
    test_reset_midrun();
    test_led_clear();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
